// File: rtl/ldr_lamp_ctrl.sv
// Street-lamp controller: 4-sample moving average of LDR readings feeding a hysteresis FSM.
// Build option: define LDR_SUNLIGHT_OVERRIDE_EN to let the upstream sunlight flag force "bright" at night.
module ldr_lamp_ctrl #(
   parameter int DARK_THRESHOLD  = 100,
   parameter int LIGHT_THRESHOLD = 200,
   parameter int HOLD_SAMPLES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [7:0] ldr_data,
   input  logic       sunlight,
   output logic [7:0] avg_level,
   output logic       avg_valid,
   output logic       lamp_on,
   output logic       lamp_toggle,
   output logic [1:0] state
);

   typedef enum logic [1:0] {DAY = 2'd0, DUSK_PEND = 2'd1, NIGHT = 2'd2, DAWN_PEND = 2'd3} state_t;

   localparam logic [7:0] DARK_T  = 8'(DARK_THRESHOLD);
   localparam logic [7:0] LIGHT_T = 8'(LIGHT_THRESHOLD);
   localparam logic [3:0] HOLD_T  = 4'(HOLD_SAMPLES);
`ifdef LDR_SUNLIGHT_OVERRIDE_EN
   localparam logic SUN_OVERRIDE = 1'b1;
`else
   localparam logic SUN_OVERRIDE = 1'b0;
`endif

   logic [3:0][7:0] win;
   logic [9:0]      sum, sum_nxt;
   logic            empty;
   logic            sun_d;
   state_t          cur, cur_nxt;
   logic [3:0]      cnt, cnt_nxt, cnt_inc;
   logic            dark, bright;

   // First sample primes the whole window so the average starts unbiased.
   assign sum_nxt = empty ? {ldr_data, 2'b00}
                          : sum - {2'b00, win[3]} + {2'b00, ldr_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         win       <= '0;
         sum       <= '0;
         empty     <= 1'b1;
         sun_d     <= 1'b0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= sample_valid;
         if (sample_valid) begin
            win   <= empty ? {4{ldr_data}} : {win[2:0], ldr_data};
            sum   <= sum_nxt;
            empty <= 1'b0;
            sun_d <= sunlight;
         end
      end
   end

   assign avg_level = sum[9:2];

   assign dark    = avg_level < DARK_T;
   assign bright  = (avg_level > LIGHT_T) | (sun_d & SUN_OVERRIDE);
   assign cnt_inc = cnt + 4'd1;

   always_comb begin
      cur_nxt = cur;
      cnt_nxt = cnt;
      if (avg_valid) begin
         case (cur)
            DAY: begin
               if (dark) begin
                  cnt_nxt = 4'd1;
                  cur_nxt = (HOLD_T == 4'd1) ? NIGHT : DUSK_PEND;
               end else cnt_nxt = 4'd0;
            end
            DUSK_PEND: begin
               if (dark) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == HOLD_T) cur_nxt = NIGHT;
               end else begin
                  cur_nxt = DAY;
                  cnt_nxt = 4'd0;
               end
            end
            NIGHT: begin
               if (bright) begin
                  cnt_nxt = 4'd1;
                  cur_nxt = (HOLD_T == 4'd1) ? DAY : DAWN_PEND;
               end else cnt_nxt = 4'd0;
            end
            default: begin
               if (bright) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == HOLD_T) cur_nxt = DAY;
               end else begin
                  cur_nxt = NIGHT;
                  cnt_nxt = 4'd0;
               end
            end
         endcase
      end
   end

   // Lamp is lit in NIGHT and DAWN_PEND, i.e. whenever state bit 1 is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= DAY;
         cnt         <= 4'd0;
         lamp_toggle <= 1'b0;
      end else begin
         cur         <= cur_nxt;
         cnt         <= cnt_nxt;
         lamp_toggle <= cur_nxt[1] ^ cur[1];
      end
   end

   assign lamp_on = cur[1];
   assign state   = cur;

endmodule

// File: tb/tb_ldr_lamp_ctrl.sv
// Directed bench for ldr_lamp_ctrl with default thresholds 100/200 and HOLD_SAMPLES=3.
module tb_ldr_lamp_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] ldr_data = '0;
   logic       sunlight = 1'b0;
   logic [7:0] avg_level;
   logic       avg_valid, lamp_on, lamp_toggle;
   logic [1:0] state;
   int n_chk = 0;
   int n_fail = 0;

   ldr_lamp_ctrl dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .ldr_data(ldr_data),
      .sunlight(sunlight), .avg_level(avg_level), .avg_valid(avg_valid),
      .lamp_on(lamp_on), .lamp_toggle(lamp_toggle), .state(state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one sample for one clock (valid left high for back-to-back use)
   task automatic drive(input logic [7:0] d, input logic s);
      sample_valid = 1'b1; ldr_data = d; sunlight = s;
      step();
   endtask

   task automatic idle();
      sample_valid = 1'b0; sunlight = 1'b0;
      step();
   endtask

   // single sample then one idle cycle so the FSM has consumed it
   task automatic one(input logic [7:0] d, input logic s);
      drive(d, s);
      idle();
   endtask

   task automatic do_reset();
      sample_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (avg_level !== 8'd0) begin n_fail++; $display("FAIL reset_avg got %0d want 0", avg_level); end
      n_chk++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got %b want 0", avg_valid); end
      n_chk++; if (lamp_on !== 1'b0 || lamp_toggle !== 1'b0) begin n_fail++; $display("FAIL reset_lamp got %b/%b want 0/0", lamp_on, lamp_toggle); end
      n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
   endtask

   task automatic test_steady();
      do_reset();
      drive(8'd180, 1'b0);
      n_chk++; if (avg_level !== 8'd180 || avg_valid !== 1'b1) begin n_fail++; $display("FAIL steady_first_avg got %0d/%b want 180/1", avg_level, avg_valid); end
      for (int i = 0; i < 4; i++) drive(8'd180, 1'b0);
      idle();
      n_chk++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL steady_valid_drop got %b want 0", avg_valid); end
      n_chk++; if (state !== 2'd0 || lamp_on !== 1'b0) begin n_fail++; $display("FAIL steady_day got %0d/%b want 0/0", state, lamp_on); end
      // exactly at the dark threshold is not dark
      do_reset();
      one(8'd100, 1'b0);
      n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL dark_boundary got %0d want 0", state); end
   endtask

   task automatic test_dusk();
      do_reset();
      for (int i = 0; i < 3; i++) drive(8'd20, 1'b0);
      n_chk++; if (state !== 2'd1 || lamp_on !== 1'b0) begin n_fail++; $display("FAIL dusk_pending got %0d/%b want 1/0", state, lamp_on); end
      idle();
      n_chk++; if (state !== 2'd2 || lamp_on !== 1'b1 || lamp_toggle !== 1'b1) begin n_fail++; $display("FAIL dusk_night got %0d/%b/%b want 2/1/1", state, lamp_on, lamp_toggle); end
      idle();
      n_chk++; if (lamp_on !== 1'b1 || lamp_toggle !== 1'b0) begin n_fail++; $display("FAIL dusk_toggle_pulse got %b/%b want 1/0", lamp_on, lamp_toggle); end
   endtask

   task automatic test_band();
      // averages 52,85,117,150 then 150: none is bright
      for (int i = 0; i < 6; i++) begin
         drive(8'd150, 1'b0);
         n_chk++; if (lamp_on !== 1'b1 || lamp_toggle !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL band_hold[%0d] got %b/%b/%0d want 1/0/2", i, lamp_on, lamp_toggle, state); end
      end
      idle();
      n_chk++; if (avg_level !== 8'd150 || lamp_on !== 1'b1) begin n_fail++; $display("FAIL band_avg got %0d/%b want 150/1", avg_level, lamp_on); end
   endtask

   task automatic test_dusk_abort();
      logic [1:0] exp_st [6] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
      logic [7:0] dat    [6] = '{8'd90, 8'd90, 8'd210, 8'd0, 8'd0, 8'd0};
      logic [7:0] exp_avg[6] = '{8'd90, 8'd90, 8'd120, 8'd97, 8'd75, 8'd52};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         one(dat[i], 1'b0);
         n_chk++; if (state !== exp_st[i] || avg_level !== exp_avg[i]) begin n_fail++; $display("FAIL dusk_abort[%0d] got st %0d avg %0d want st %0d avg %0d", i, state, avg_level, exp_st[i], exp_avg[i]); end
      end
   endtask

   task automatic test_sunlight();
`ifdef LDR_SUNLIGHT_OVERRIDE_EN
      logic [1:0] exp_st [3] = '{2'd3, 2'd3, 2'd0};
`else
      logic [1:0] exp_st [3] = '{2'd2, 2'd2, 2'd2};
`endif
      for (int i = 0; i < 3; i++) begin
         one(8'd30, 1'b1);
         n_chk++; if (state !== exp_st[i] || lamp_on !== exp_st[i][1]) begin n_fail++; $display("FAIL sunlight[%0d] got st %0d lamp %b want st %0d lamp %b", i, state, lamp_on, exp_st[i], exp_st[i][1]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) drive(8'd20, 1'b0);
      idle();
      // averages 78,137,196,255: only the last is bright
      for (int i = 0; i < 4; i++) drive(8'd255, 1'b0);
      idle();
      n_chk++; if (state !== 2'd3 || lamp_on !== 1'b1) begin n_fail++; $display("FAIL dawn_pending got %0d/%b want 3/1", state, lamp_on); end
      // reset wins over a simultaneous sample
      rst = 1'b1; sample_valid = 1'b1; ldr_data = 8'd99;
      step();
      rst = 1'b0; sample_valid = 1'b0;
      n_chk++; if (state !== 2'd0 || lamp_on !== 1'b0 || lamp_toggle !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fsm got %0d/%b/%b want 0/0/0", state, lamp_on, lamp_toggle); end
      n_chk++; if (avg_level !== 8'd0 || avg_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_avg got %0d/%b want 0/0", avg_level, avg_valid); end
      drive(8'd40, 1'b0);
      n_chk++; if (avg_level !== 8'd40 || avg_valid !== 1'b1) begin n_fail++; $display("FAIL reprime got %0d/%b want 40/1", avg_level, avg_valid); end
      idle();
      n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL reprime_state got %0d want 1", state); end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_dusk();
      test_band();
      test_dusk_abort();
      test_sunlight();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
